// File: rtl/dlf_pi_gear_if.sv
// Sample-in / filter-out bundle between the phase detector and the DLF/FLB side.
// master: drives phe/phe_vld and observes the filter outputs; slave: the loop filter.
// Signals: phe, phe_vld (in to filter); dlf_out, dlf_out_vld, dlf_gear, dlf_lock, dlf_sat (out).
interface dlf_pi_gear_if #(
    parameter int PHE_W = 10,
    parameter int OUT_W = 16
);
    logic signed [PHE_W-1:0] phe;
    logic                    phe_vld;
    logic [OUT_W-1:0]        dlf_out;
    logic                    dlf_out_vld;
    logic                    dlf_gear;
    logic                    dlf_lock;
    logic                    dlf_sat;

    modport master (
        output phe, phe_vld,
        input  dlf_out, dlf_out_vld, dlf_gear, dlf_lock, dlf_sat
    );

    modport slave (
        input  phe, phe_vld,
        output dlf_out, dlf_out_vld, dlf_gear, dlf_lock, dlf_sat
    );
endinterface

// File: rtl/dlf_pi_gear.sv
// PI loop filter with acquisition/tracking gear shift and lock detect; feeds the FLB code.
// Latency: dlf_out/dlf_out_vld/dlf_sat registered one ref_clk after an accepted phe_vld.
// Backpressure: none; every phe_vld in ACQ/TRK with csr_dlf_en=1 is consumed.
// Ports: ref_clk, csr_dlf_rst (sync, active-high), csr_dlf_* config, dlf (slave side of
// dlf_pi_gear_if: phe/phe_vld in, dlf_out/dlf_out_vld/dlf_gear/dlf_lock/dlf_sat out).
// Optional macro DLF_DITHER_EN adds LFSR dither ahead of the output truncation.
module dlf_pi_gear #(
    parameter int PHE_W  = 10,
    parameter int OUT_W  = 16,
    parameter int FRAC_W = 8,
    parameter int ACC_W  = OUT_W + FRAC_W + 2
) (
    input  logic               ref_clk,
    input  logic               csr_dlf_rst,
    input  logic               csr_dlf_en,
    input  logic [3:0]         csr_dlf_kp_acq,
    input  logic [3:0]         csr_dlf_ki_acq,
    input  logic [3:0]         csr_dlf_kp_trk,
    input  logic [3:0]         csr_dlf_ki_trk,
    input  logic [7:0]         csr_dlf_gear_cycles,
    input  logic [PHE_W-2:0]   csr_dlf_lock_thr,
    input  logic [7:0]         csr_dlf_lock_len,
    input  logic [OUT_W-1:0]   csr_dlf_init,
    dlf_pi_gear_if.slave       dlf
);
    // One spare bit over the integrator so integ+iterm (+pterm, +dither) never wraps.
    localparam int SUM_W = ACC_W + 1;

    localparam logic signed [SUM_W-1:0] INTEG_MAX =
        {{(SUM_W-OUT_W-FRAC_W){1'b0}}, {OUT_W{1'b1}}, {FRAC_W{1'b0}}};
    localparam logic signed [SUM_W-1:0] OUT_MAX =
        {{(SUM_W-OUT_W){1'b0}}, {OUT_W{1'b1}}};

    typedef enum logic [1:0] {IDLE, ACQ, TRK} state_t;

    state_t                   state;
    logic signed [ACC_W-1:0]  integ;
    logic [OUT_W-1:0]         out_r;
    logic                     vld_r;
    logic                     gear_r;
    logic                     lock_r;
    logic                     sat_r;
    logic [7:0]               gear_cnt;
    logic [7:0]               lock_cnt;
    logic [15:0]              lfsr;

    logic [3:0]               kp;
    logic [3:0]               ki;
    logic signed [ACC_W-1:0]  e;
    logic signed [ACC_W-1:0]  iterm;
    logic signed [ACC_W-1:0]  pterm;
    logic signed [SUM_W-1:0]  integ_raw;
    logic signed [ACC_W-1:0]  integ_n;
    logic signed [SUM_W-1:0]  dith;
    logic signed [SUM_W-1:0]  sum;
    logic signed [SUM_W-1:0]  out_full;
    logic [OUT_W-1:0]         out_n;
    logic                     sat_i;
    logic                     sat_o;
    logic [PHE_W:0]           phe_ext;
    logic [PHE_W:0]           phe_abs;
    logic                     in_win;
    logic [7:0]               gear_cnt_n;
    logic [7:0]               lock_cnt_n;
    logic [15:0]              lfsr_n;

    always_comb begin
        kp = (state == TRK) ? csr_dlf_kp_trk : csr_dlf_kp_acq;
        ki = (state == TRK) ? csr_dlf_ki_trk : csr_dlf_ki_acq;

        // Phase error aligned to the integrator's fractional point.
        e     = {{(ACC_W-PHE_W-FRAC_W){dlf.phe[PHE_W-1]}}, dlf.phe, {FRAC_W{1'b0}}};
        iterm = e >>> ki;
        pterm = e >>> kp;

        integ_raw = SUM_W'(integ) + SUM_W'(iterm);
        sat_i     = 1'b0;
        integ_n   = integ_raw[ACC_W-1:0];
        if (integ_raw < 0) begin
            integ_n = '0;
            sat_i   = 1'b1;
        end else if (integ_raw > INTEG_MAX) begin
            integ_n = INTEG_MAX[ACC_W-1:0];
            sat_i   = 1'b1;
        end

        dith = '0;
`ifdef DLF_DITHER_EN
        dith[FRAC_W-1:0] = lfsr[FRAC_W-1:0];
`endif
        lfsr_n = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};

        sum      = SUM_W'(integ_n) + SUM_W'(pterm) + dith;
        out_full = sum >>> FRAC_W;    // arithmetic shift == floor for negative sums
        sat_o    = 1'b0;
        out_n    = out_full[OUT_W-1:0];
        if (out_full < 0) begin
            out_n = '0;
            sat_o = 1'b1;
        end else if (out_full > OUT_MAX) begin
            out_n = {OUT_W{1'b1}};
            sat_o = 1'b1;
        end

        // |phe| needs one extra bit so that the most negative code maps to +2^(PHE_W-1).
        phe_ext    = {dlf.phe[PHE_W-1], dlf.phe};
        phe_abs    = dlf.phe[PHE_W-1] ? (~phe_ext + 1'b1) : phe_ext;
        in_win     = (phe_abs <= {2'b00, csr_dlf_lock_thr});
        gear_cnt_n = gear_cnt + 8'd1;
        lock_cnt_n = (lock_cnt == 8'hFF) ? 8'hFF : lock_cnt + 8'd1;
    end

    always_ff @(posedge ref_clk) begin
        if (csr_dlf_rst) begin
            state    <= IDLE;
            integ    <= {{(ACC_W-OUT_W-FRAC_W){1'b0}}, csr_dlf_init, {FRAC_W{1'b0}}};
            out_r    <= csr_dlf_init;
            vld_r    <= 1'b0;
            gear_r   <= 1'b0;
            lock_r   <= 1'b0;
            sat_r    <= 1'b0;
            gear_cnt <= '0;
            lock_cnt <= '0;
            lfsr     <= 16'hACE1;
        end else if (!csr_dlf_en) begin
            // Freeze integrator/output; drop back to acquisition on the next enable.
            state    <= IDLE;
            vld_r    <= 1'b0;
            gear_r   <= 1'b0;
            lock_r   <= 1'b0;
            gear_cnt <= '0;
            lock_cnt <= '0;
        end else begin
            vld_r <= 1'b0;
            case (state)
                IDLE: begin
                    // Enable-rise cycle: samples are not taken here.
                    if (csr_dlf_gear_cycles == 8'd0) begin
                        state  <= TRK;
                        gear_r <= 1'b1;
                    end else begin
                        state  <= ACQ;
                    end
                end
                ACQ, TRK: begin
                    if (dlf.phe_vld) begin
                        integ <= integ_n;
                        out_r <= out_n;
                        sat_r <= sat_i | sat_o;
                        vld_r <= 1'b1;
`ifdef DLF_DITHER_EN
                        lfsr  <= lfsr_n;
`endif
                        if (state == ACQ) begin
                            gear_cnt <= gear_cnt_n;
                            if (gear_cnt_n == csr_dlf_gear_cycles) begin
                                state  <= TRK;
                                gear_r <= 1'b1;
                            end
                        end else if (in_win) begin
                            lock_cnt <= lock_cnt_n;
                            if ((csr_dlf_lock_len != 8'd0) && (lock_cnt_n >= csr_dlf_lock_len))
                                lock_r <= 1'b1;
                        end else begin
                            lock_cnt <= '0;
                            lock_r   <= 1'b0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign dlf.dlf_out     = out_r;
    assign dlf.dlf_out_vld = vld_r;
    assign dlf.dlf_gear    = gear_r;
    assign dlf.dlf_lock    = lock_r;
    assign dlf.dlf_sat     = sat_r;
endmodule

// File: tb/tb_dlf_pi_gear.sv
// Bench for dlf_pi_gear: directed scenarios plus randomized traffic, all checked each cycle
// against a cycle-level behavioural model of the loop filter written in integer arithmetic.
module tb_dlf_pi_gear;
    localparam int PHE_W  = 10;
    localparam int OUT_W  = 16;
    localparam int FRAC_W = 8;

    logic ref_clk = 1'b0;
    always #5 ref_clk = ~ref_clk;

    logic             csr_dlf_rst = 1'b1;
    logic             csr_dlf_en  = 1'b0;
    logic [3:0]       kp_acq = '0, ki_acq = '0, kp_trk = '0, ki_trk = '0;
    logic [7:0]       gear_cycles = 8'd255;
    logic [PHE_W-2:0] lock_thr = '0;
    logic [7:0]       lock_len = '0;
    logic [OUT_W-1:0] init_code = 16'h8000;

    dlf_pi_gear_if #(.PHE_W(PHE_W), .OUT_W(OUT_W)) dif();

    dlf_pi_gear #(.PHE_W(PHE_W), .OUT_W(OUT_W), .FRAC_W(FRAC_W)) u_dut (
        .ref_clk             (ref_clk),
        .csr_dlf_rst         (csr_dlf_rst),
        .csr_dlf_en          (csr_dlf_en),
        .csr_dlf_kp_acq      (kp_acq),
        .csr_dlf_ki_acq      (ki_acq),
        .csr_dlf_kp_trk      (kp_trk),
        .csr_dlf_ki_trk      (ki_trk),
        .csr_dlf_gear_cycles (gear_cycles),
        .csr_dlf_lock_thr    (lock_thr),
        .csr_dlf_lock_len    (lock_len),
        .csr_dlf_init        (init_code),
        .dlf                 (dif)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
        end
    endtask

    // Sample stimulus as seen by the model.
    bit vld_i = 1'b0;
    int phe_i = 0;

    task automatic drive(input bit v, input int p);
        vld_i       = v;
        phe_i       = p;
        dif.phe_vld = v;
        dif.phe     = PHE_W'(p);
    endtask

    // Behavioural model. mode: 0 idle, 1 acquiring, 2 tracking.
    int        m_mode = 0, m_gcnt = 0, m_lcnt = 0;
    int        m_integ = 0, m_out = 0;
    bit        m_vld = 0, m_gear = 0, m_lock = 0, m_sat = 0;
    bit [15:0] m_lfsr = 16'hACE1;

    // floor(v / 2^k) using only integer division.
    function automatic int fdiv(input int v, input int k);
        int d = 1 << k;
        if (v >= 0) return v / d;
        return -((-v + d - 1) / d);
    endfunction

    task automatic model_edge();
        int kp, ki, e, integ, sum, o, dither, mag;
        bit sat;
        if (csr_dlf_rst) begin
            m_integ = int'(init_code) * 256; m_out = int'(init_code);
            m_vld = 0; m_gear = 0; m_lock = 0; m_sat = 0;
            m_gcnt = 0; m_lcnt = 0; m_mode = 0; m_lfsr = 16'hACE1;
        end else if (!csr_dlf_en) begin
            m_mode = 0; m_gcnt = 0; m_lcnt = 0; m_lock = 0; m_gear = 0; m_vld = 0;
        end else if (m_mode == 0) begin
            m_vld = 0;
            if (gear_cycles == 0) begin m_mode = 2; m_gear = 1; end
            else m_mode = 1;
        end else begin
            m_vld = vld_i;
            if (vld_i) begin
                kp = (m_mode == 2) ? int'(kp_trk) : int'(kp_acq);
                ki = (m_mode == 2) ? int'(ki_trk) : int'(ki_acq);
                e  = phe_i * 256;
                sat = 0;
                integ = m_integ + fdiv(e, ki);
                if (integ < 0) begin integ = 0; sat = 1; end
                else if (integ > 65535 * 256) begin integ = 65535 * 256; sat = 1; end
                dither = 0;
`ifdef DLF_DITHER_EN
                dither = int'(m_lfsr[7:0]);
                m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
`endif
                sum = integ + fdiv(e, kp) + dither;
                o = fdiv(sum, 8);
                if (o < 0) begin o = 0; sat = 1; end
                else if (o > 65535) begin o = 65535; sat = 1; end
                m_integ = integ; m_out = o; m_sat = sat;
                if (m_mode == 1) begin
                    m_gcnt = (m_gcnt + 1) % 256;
                    if (m_gcnt == int'(gear_cycles)) begin m_mode = 2; m_gear = 1; end
                end else begin
                    mag = (phe_i < 0) ? -phe_i : phe_i;
                    if (mag <= int'(lock_thr)) begin
                        if (m_lcnt < 255) m_lcnt++;
                        if (lock_len != 0 && m_lcnt >= int'(lock_len)) m_lock = 1;
                    end else begin
                        m_lcnt = 0; m_lock = 0;
                    end
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge ref_clk);
        model_edge();
        #1;
        chk("dlf_out",     32'(dif.dlf_out),     32'(m_out));
        chk("dlf_out_vld", 32'(dif.dlf_out_vld), 32'(m_vld));
        chk("dlf_gear",    32'(dif.dlf_gear),    32'(m_gear));
        chk("dlf_lock",    32'(dif.dlf_lock),    32'(m_lock));
        chk("dlf_sat",     32'(dif.dlf_sat),     32'(m_sat));
    endtask

    task automatic do_reset(input logic [15:0] init);
        init_code   = init;
        csr_dlf_rst = 1'b1;
        csr_dlf_en  = 1'b0;
        drive(0, 0);
        tick(); tick();
        csr_dlf_rst = 1'b0;
    endtask

    initial begin
        logic [15:0] prev, frozen;
        drive(0, 0);

        // 1: reset, hold disabled, strobes ignored
        do_reset(16'h8000);
        chk("t1_out", 32'(dif.dlf_out), 32'h8000);
        drive(1, 100); tick(); tick();
        chk("t1_out_hold", 32'(dif.dlf_out), 32'h8000);
        chk("t1_vld", 32'(dif.dlf_out_vld), 32'h0);

        // 2: acquisition with unity gains
        gear_cycles = 8'd255; kp_acq = 4'd0; ki_acq = 4'd0;
        csr_dlf_en = 1'b1; drive(1, 16);
        tick();
        chk("t2_enrise_novld", 32'(dif.dlf_out_vld), 32'h0);
        tick(); chk("t2_s1", 32'(dif.dlf_out), 32'h8020);
        tick(); chk("t2_s2", 32'(dif.dlf_out), 32'h8030);
        tick(); chk("t2_s3", 32'(dif.dlf_out), 32'h8040);
        drive(0, 16); tick();
        chk("t2_vld_strobe", 32'(dif.dlf_out_vld), 32'h0);

        // 3: gear shift after 4 samples
        do_reset(16'h8000);
        gear_cycles = 8'd4; ki_trk = 4'd4; kp_trk = 4'd15;
        csr_dlf_en = 1'b1; tick();
        drive(1, 16);
        tick(); tick(); tick();
        chk("t3_gear_pre", 32'(dif.dlf_gear), 32'h0);
        tick();
        chk("t3_gear_post", 32'(dif.dlf_gear), 32'h1);
        tick(); chk("t3_s5", 32'(dif.dlf_out), 32'h8041);
        prev = dif.dlf_out;
        tick(); chk("t3_step", 32'(dif.dlf_out - prev), 32'h1);

        // 4: top clamp and release
        do_reset(16'hFFF0);
        gear_cycles = 8'd255;
        csr_dlf_en = 1'b1; tick();
        drive(1, 511); tick();
        chk("t4_out_clamp", 32'(dif.dlf_out), 32'hFFFF);
        chk("t4_sat", 32'(dif.dlf_sat), 32'h1);
        drive(1, -1); tick();
        chk("t4_out_release", 32'(dif.dlf_out), 32'hFFFD);
        chk("t4_sat_clear", 32'(dif.dlf_sat), 32'h0);

        // 5: lock detect in tracking
        do_reset(16'h8000);
        gear_cycles = 8'd0; kp_trk = 4'd15; ki_trk = 4'd15;
        lock_thr = 9'd4; lock_len = 8'd8;
        csr_dlf_en = 1'b1; drive(0, 0); tick();
        chk("t5_gear_direct", 32'(dif.dlf_gear), 32'h1);
        for (int i = 0; i < 7; i++) begin drive(1, 3); tick(); end
        drive(1, 5); tick();
        chk("t5_lock_after5", 32'(dif.dlf_lock), 32'h0);
        for (int i = 0; i < 7; i++) begin drive(1, -4); tick(); end
        chk("t5_lock_7", 32'(dif.dlf_lock), 32'h0);
        tick();
        chk("t5_lock_8", 32'(dif.dlf_lock), 32'h1);
        drive(1, -512); tick();
        chk("t5_lock_clr", 32'(dif.dlf_lock), 32'h0);

        // 6: disable freezes, re-enable resumes in ACQ, reset mid-run
        for (int i = 0; i < 8; i++) begin drive(1, 0); tick(); end
        chk("t6_lock_pre", 32'(dif.dlf_lock), 32'h1);
        frozen = dif.dlf_out;
        csr_dlf_en = 1'b0; drive(1, 100); tick(); tick();
        chk("t6_frozen", 32'(dif.dlf_out), 32'(frozen));
        chk("t6_lock_off", 32'(dif.dlf_lock), 32'h0);
        chk("t6_gear_off", 32'(dif.dlf_gear), 32'h0);
        gear_cycles = 8'd4;
        csr_dlf_en = 1'b1; drive(1, 0); tick();
        chk("t6_resume_hold", 32'(dif.dlf_out), 32'(frozen));
        tick();
        chk("t6_resume_acq", 32'(dif.dlf_gear), 32'h0);
        chk("t6_resume_val", 32'(dif.dlf_out), 32'(frozen));
        init_code = 16'h1234; csr_dlf_rst = 1'b1; drive(1, 50); tick();
        chk("t6_rst_out", 32'(dif.dlf_out), 32'h1234);
        chk("t6_rst_vld", 32'(dif.dlf_out_vld), 32'h0);
        csr_dlf_rst = 1'b0;

        // Randomized traffic against the model
        for (int cyc = 0; cyc < 4000; cyc++) begin
            int p;
            if ($urandom_range(299) == 0) begin
                csr_dlf_rst = 1'b1;
                case ($urandom_range(2))
                    0: init_code = 16'(32'hFFFF - $urandom_range(64));
                    1: init_code = 16'($urandom_range(64));
                    default: init_code = 16'($urandom);
                endcase
            end else begin
                csr_dlf_rst = 1'b0;
            end
            if (csr_dlf_en && $urandom_range(149) == 0) csr_dlf_en = 1'b0;
            else if (!csr_dlf_en && $urandom_range(4) == 0) csr_dlf_en = 1'b1;
            if ($urandom_range(49) == 0) begin
                kp_acq = 4'($urandom); ki_acq = 4'($urandom);
                kp_trk = 4'($urandom); ki_trk = 4'($urandom);
                gear_cycles = 8'($urandom_range(20));
                lock_thr = 9'($urandom_range(40));
                lock_len = 8'($urandom_range(10));
            end
            case ($urandom_range(3))
                0: p = int'($urandom_range(1023)) - 512;
                1: p = ($urandom_range(1) == 1) ? 511 : -512;
                default: p = int'($urandom_range(40)) - 20;
            endcase
            drive(($urandom_range(9) < 7), p);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
